// File: rtl/interconnect_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : interconnect_bank_arbiter (plus interconnect_common_pkg)
// Brief    : Per-bank load/store arbiter for the global-memory interconnect.
//            Optional per-bank conflict counters: INTERCONNECT_ARB_STATS_EN
// Revision : 1.0 - initial release
// ============================================================================

package interconnect_common_pkg;
    localparam int N_PE               = 4;
    localparam int N_GLOBAL_MEM_BANKS = 4;
    localparam int c_BANK_ID_W        = $clog2(N_GLOBAL_MEM_BANKS);
    localparam int c_PE_ID_W          = $clog2(N_PE);
endpackage

module interconnect_bank_arbiter
    import interconnect_common_pkg::*;
#(
`ifdef INTERCONNECT_ARB_STATS_EN
    parameter int STAT_CNT_L      = 16,
`endif
    parameter int LD_STARVE_LIMIT = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [N_PE-1:0]                               ld_req,
    input  logic [N_PE-1:0][c_BANK_ID_W-1:0]              ld_mem_bank_id,
    input  logic [N_PE-1:0]                               st_req,
    input  logic [N_PE-1:0][c_BANK_ID_W-1:0]              st_mem_bank_id,
    input  logic                                          init_mem_vld,
    output logic [N_PE-1:0]                               ld_gnt,
    output logic [N_PE-1:0]                               st_gnt,
    output logic [N_GLOBAL_MEM_BANKS-1:0][c_PE_ID_W:0]    granted_requester_id,
    output logic [N_GLOBAL_MEM_BANKS-1:0]                 grant_out_port_wise
`ifdef INTERCONNECT_ARB_STATS_EN
    ,
    output logic [N_GLOBAL_MEM_BANKS-1:0][STAT_CNT_L-1:0] conflict_cnt
`endif
);

    localparam int              c_SW    = $clog2(LD_STARVE_LIMIT + 1);
    localparam logic [c_SW-1:0] c_LIMIT = c_SW'(LD_STARVE_LIMIT);

    // First requester at or above ptr, wrapping N_PE-1 -> 0.
    function automatic logic [c_PE_ID_W-1:0] rr_pick(input logic [N_PE-1:0] req,
                                                     input logic [c_PE_ID_W-1:0] ptr);
        logic [c_PE_ID_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_PE - 1; i >= 0; i--) begin
            idx = c_PE_ID_W'((int'(ptr) + i) % N_PE);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [c_PE_ID_W-1:0] ptr_next(input logic [c_PE_ID_W-1:0] k);
        ptr_next = c_PE_ID_W'((int'(k) + 1) % N_PE);
    endfunction

    logic                    w_run;
    logic [N_PE-1:0]         w_ld_onehot [N_GLOBAL_MEM_BANKS];
    logic [N_PE-1:0]         w_st_onehot [N_GLOBAL_MEM_BANKS];

    // Reset and init both force the idle value onto every output.
    assign w_run = rst && !init_mem_vld;

    for (genvar b = 0; b < N_GLOBAL_MEM_BANKS; b++) begin : g_bank
        logic [N_PE-1:0]      w_s;
        logic [N_PE-1:0]      w_l;
        logic [c_PE_ID_W-1:0] r_st_ptr;
        logic [c_PE_ID_W-1:0] r_ld_ptr;
        logic [c_SW-1:0]      r_starve;
        logic [c_PE_ID_W-1:0] w_st_k;
        logic [c_PE_ID_W-1:0] w_ld_k;
        logic                 w_st_sel;
        logic                 w_st_win;
        logic                 w_ld_win;

        always_comb begin
            w_s = '0;
            w_l = '0;
            for (int p = 0; p < N_PE; p++) begin
                w_s[p] = st_req[p] && (st_mem_bank_id[p] == c_BANK_ID_W'(b));
                w_l[p] = ld_req[p] && (ld_mem_bank_id[p] == c_BANK_ID_W'(b));
            end
        end

        assign w_st_k   = rr_pick(w_s, r_st_ptr);
        assign w_ld_k   = rr_pick(w_l, r_ld_ptr);
        assign w_st_sel = (|w_s) && (!(|w_l) || (r_starve < c_LIMIT));
        assign w_st_win = w_run && w_st_sel;
        assign w_ld_win = w_run && !w_st_sel && (|w_l);

        assign grant_out_port_wise[b]  = w_st_win || w_ld_win;
        // Idle banks present a load id so the datapath never sees a stray write.
        assign granted_requester_id[b] = w_st_win ? {1'b0, w_st_k}
                                                  : {1'b1, (w_ld_win ? w_ld_k : '0)};
        assign w_ld_onehot[b] = {N_PE{w_ld_win}} & (N_PE'(1) << w_ld_k);
        assign w_st_onehot[b] = {N_PE{w_st_win}} & (N_PE'(1) << w_st_k);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_st_ptr <= '0;
                r_ld_ptr <= '0;
                r_starve <= '0;
            end else if (!init_mem_vld) begin
                if (w_st_win) begin
                    r_st_ptr <= ptr_next(w_st_k);
                    if (|w_l) r_starve <= (r_starve == c_LIMIT) ? c_LIMIT : r_starve + 1'b1;
                    else      r_starve <= '0;
                end else begin
                    if (w_ld_win) r_ld_ptr <= ptr_next(w_ld_k);
                    r_starve <= '0;
                end
            end
        end

`ifdef INTERCONNECT_ARB_STATS_EN
        localparam int c_SUM_W = STAT_CNT_L + 1;
        logic [STAT_CNT_L-1:0] r_cnt;
        logic [c_SUM_W-1:0]    w_sum;

        // One spare bit catches the carry so the counter can saturate.
        always_comb begin
            w_sum = {1'b0, r_cnt};
            for (int p = 0; p < N_PE; p++) begin
                w_sum = w_sum + c_SUM_W'(w_s[p]) + c_SUM_W'(w_l[p]);
            end
            w_sum = w_sum - c_SUM_W'(w_st_win || w_ld_win);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)               r_cnt <= '0;
            else if (!init_mem_vld) r_cnt <= w_sum[STAT_CNT_L] ? '1 : w_sum[STAT_CNT_L-1:0];
        end

        assign conflict_cnt[b] = r_cnt;
`endif
    end

    always_comb begin
        ld_gnt = '0;
        st_gnt = '0;
        for (int b = 0; b < N_GLOBAL_MEM_BANKS; b++) begin
            ld_gnt = ld_gnt | w_ld_onehot[b];
            st_gnt = st_gnt | w_st_onehot[b];
        end
    end

    always_comb begin
        for (int b = 0; b < N_GLOBAL_MEM_BANKS; b++) begin
            assert ($onehot0({w_ld_onehot[b], w_st_onehot[b]}));
        end
        assert ((ld_gnt & ~ld_req) == '0);
        assert ((st_gnt & ~st_req) == '0);
        for (int p = 0; p < N_PE; p++) begin
            for (int q = p + 1; q < N_PE; q++) begin
                assert (!(ld_gnt[p] && ld_gnt[q] && (ld_mem_bank_id[p] == ld_mem_bank_id[q])));
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interconnect_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_interconnect_bank_arbiter
// Brief    : Directed bench for interconnect_bank_arbiter (N_PE=4, 4 banks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interconnect_bank_arbiter;
    import interconnect_common_pkg::*;

    logic                                       clk = 1'b0;
    logic                                       rst = 1'b0;
    logic [N_PE-1:0]                            ld_req = '0;
    logic [N_PE-1:0][c_BANK_ID_W-1:0]           ld_bank = '0;
    logic [N_PE-1:0]                            st_req = '0;
    logic [N_PE-1:0][c_BANK_ID_W-1:0]           st_bank = '0;
    logic                                       init_vld = 1'b0;
    logic [N_PE-1:0]                            ld_gnt;
    logic [N_PE-1:0]                            st_gnt;
    logic [N_GLOBAL_MEM_BANKS-1:0][c_PE_ID_W:0] gid;
    logic [N_GLOBAL_MEM_BANKS-1:0]              gop;
`ifdef INTERCONNECT_ARB_STATS_EN
    logic [N_GLOBAL_MEM_BANKS-1:0][15:0]        cnt;
`endif

    int vectors = 0;
    int errs    = 0;

    // Starvation scenario on bank 1: st pe0/pe1 and ld pe3.
    logic [3:0] c_exp_st  [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0001};
    logic [3:0] c_exp_ld  [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [2:0] c_exp_id1 [6] = '{3'b000,  3'b001,  3'b000,  3'b001,  3'b111,  3'b000};

    interconnect_bank_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .ld_req               (ld_req),
        .ld_mem_bank_id       (ld_bank),
        .st_req               (st_req),
        .st_mem_bank_id       (st_bank),
        .init_mem_vld         (init_vld),
        .ld_gnt               (ld_gnt),
        .st_gnt               (st_gnt),
        .granted_requester_id (gid),
        .grant_out_port_wise  (gop)
`ifdef INTERCONNECT_ARB_STATS_EN
        ,
        .conflict_cnt         (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gop"}, 32'(gop), 32'h0);
        chk({tag, "_ldg"}, 32'(ld_gnt), 32'h0);
        chk({tag, "_stg"}, 32'(st_gnt), 32'h0);
        chk({tag, "_ids"}, 32'(gid), 32'b100_100_100_100);
    endtask

    task automatic clear_reqs();
        ld_req  = '0;
        st_req  = '0;
        ld_bank = '0;
        st_bank = '0;
    endtask

    task automatic starve_setup();
        clear_reqs();
        st_req     = 4'b0011;
        st_bank[0] = 2'd1;
        st_bank[1] = 2'd1;
        ld_req     = 4'b1000;
        ld_bank[3] = 2'd1;
    endtask

    task automatic ld_all_bank2();
        ld_req  = 4'b1111;
        ld_bank = {2'd2, 2'd2, 2'd2, 2'd2};
    endtask

    initial begin
        // Reset held with requests pending: outputs must stay idle.
        ld_all_bank2();
        repeat (2) @(negedge clk);
        #1 chk_idle("rst_hold");

        // Round-robin loads on bank 2 starting right at reset release.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("rr_ldg", 32'(ld_gnt), 32'(4'b0001 << (i % 4)));
            chk("rr_id2", 32'(gid[2]), 32'({1'b1, 2'(i % 4)}));
        end

        // Load starvation protection on bank 1.
        @(negedge clk);
        starve_setup();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("stv_stg", 32'(st_gnt), 32'(c_exp_st[i]));
            chk("stv_ldg", 32'(ld_gnt), 32'(c_exp_ld[i]));
            chk("stv_id1", 32'(gid[1]), 32'(c_exp_id1[i]));
        end

        // Parallel grants across banks in one cycle.
        @(negedge clk);
        clear_reqs();
        ld_req     = 4'b0011;
        ld_bank[0] = 2'd0;
        ld_bank[1] = 2'd1;
        st_req     = 4'b0001;
        st_bank[0] = 2'd3;
        #1;
        chk("par_ldg", 32'(ld_gnt), 32'b0011);
        chk("par_stg", 32'(st_gnt), 32'b0001);
        chk("par_gop", 32'(gop), 32'b1011);
        chk("par_ids", 32'(gid), 32'b000_100_101_100);

        // No requests, then init port active with requests pending.
        @(negedge clk);
        clear_reqs();
        #1 chk_idle("noreq");
        @(negedge clk);
        ld_all_bank2();
        init_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk_idle("init");
        end
        // Bank 2 load pointer must still be 1 from the earlier round-robin.
        @(negedge clk);
        init_vld = 1'b0;
        #1;
        chk("post_init_ldg", 32'(ld_gnt), 32'b0010);
        chk("post_init_id2", 32'(gid[2]), 32'b101);

        // Starvation again: bank 1 store pointer is 1, starve reaches 3.
        @(negedge clk);
        starve_setup();
        #1 chk("pre_rst_stg0", 32'(st_gnt), 32'b0010);
        @(negedge clk);
        #1 chk("pre_rst_stg1", 32'(st_gnt), 32'b0001);
        @(negedge clk);
        #1 chk("pre_rst_stg2", 32'(st_gnt), 32'b0010);

        // Mid-operation reset: idle immediately, full state cleared.
        @(negedge clk);
        rst = 1'b0;
        #1 chk_idle("midrst_a");
        @(negedge clk);
        #1 chk_idle("midrst_b");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("post_rst_stg", 32'(st_gnt), 32'(c_exp_st[i]));
            chk("post_rst_ldg", 32'(ld_gnt), 32'(c_exp_ld[i]));
            chk("post_rst_id1", 32'(gid[1]), 32'(c_exp_id1[i]));
        end

`ifdef INTERCONNECT_ARB_STATS_EN
        // Three loaders on bank 0 for ten cycles: two losers per cycle.
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        @(negedge clk);
        rst    = 1'b1;
        ld_req = 4'b0111;
        repeat (10) @(negedge clk);
        clear_reqs();
        #1;
        chk("cnt_b0", 32'(cnt[0]), 32'd20);
        chk("cnt_b1", 32'(cnt[1]), 32'd0);
        chk("cnt_b2", 32'(cnt[2]), 32'd0);
        chk("cnt_b3", 32'(cnt[3]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
